// File: rtl/tb_core_mem.sv
// Single-cycle RV32I subset core (ADD/AND/ADDI/ANDI/SLTI/SLTIU/SLLI) with an internal,
// externally loadable instruction memory; halts with a sticky illegal flag on anything else.
module tb_core_mem #(
    parameter int unsigned PROG_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_WORDS)-1:0] prog_addr,
    input  logic [31:0]                   prog_wdata,
    input  logic [4:0]                    dbg_raddr,
    output logic [31:0]                   dbg_rdata,
    output logic [31:0]                   pc,
    output logic                          retired,
    output logic                          illegal
);
    localparam int unsigned IDX_W  = $clog2(PROG_WORDS);
    localparam logic [6:0]  OP_REG = 7'b0110011;
    localparam logic [6:0]  OP_IMM = 7'b0010011;

    logic [31:0] mem_q  [PROG_WORDS];
    logic [31:0] regs_q [32];
    logic [31:0] pc_q, pc_d;
    logic        retired_q, retired_d;
    logic        illegal_q, illegal_d;

    logic [31:0] inst_s;
    logic [6:0]  opcode_s, funct7_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [31:0] imm_s, rs1_val_s, rs2_val_s, result_s;
    logic        legal_s, wen_s;

    // The fetch index wraps inside the memory while pc itself runs over all 32 bits.
    assign inst_s    = mem_q[pc_q[IDX_W+1:2]];
    assign opcode_s  = inst_s[6:0];
    assign rd_s      = inst_s[11:7];
    assign funct3_s  = inst_s[14:12];
    assign rs1_s     = inst_s[19:15];
    assign rs2_s     = inst_s[24:20];
    assign funct7_s  = inst_s[31:25];
    assign imm_s     = {{20{inst_s[31]}}, inst_s[31:20]};
    assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : regs_q[rs1_s];
    assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : regs_q[rs2_s];
    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : regs_q[dbg_raddr];

    // Decode and execute the fetched word
    always_comb begin
        legal_s  = 1'b0;
        result_s = 32'd0;
        case (opcode_s)
            OP_REG: begin
                if (funct7_s == 7'b0000000) begin
                    case (funct3_s)
                        3'b000: begin legal_s = 1'b1; result_s = rs1_val_s + rs2_val_s; end
                        3'b111: begin legal_s = 1'b1; result_s = rs1_val_s & rs2_val_s; end
                        default: begin legal_s = 1'b0; result_s = 32'd0; end
                    endcase
                end else begin
                    legal_s = 1'b0;
                end
            end
            OP_IMM: begin
                case (funct3_s)
                    3'b000: begin legal_s = 1'b1; result_s = rs1_val_s + imm_s; end
                    3'b111: begin legal_s = 1'b1; result_s = rs1_val_s & imm_s; end
                    3'b010: begin
                        legal_s  = 1'b1;
                        result_s = {31'd0, ($signed(rs1_val_s) < $signed(imm_s))};
                    end
                    3'b011: begin legal_s = 1'b1; result_s = {31'd0, (rs1_val_s < imm_s)}; end
                    3'b001: begin
                        if (funct7_s == 7'b0000000) begin
                            legal_s  = 1'b1;
                            result_s = rs1_val_s << rs2_s;
                        end else begin
                            legal_s = 1'b0;
                        end
                    end
                    default: begin legal_s = 1'b0; result_s = 32'd0; end
                endcase
            end
            default: begin
                legal_s  = 1'b0;
                result_s = 32'd0;
            end
        endcase
    end

    // Sequencing: a program write or a halted core freezes everything for the cycle
    always_comb begin
        pc_d      = pc_q;
        retired_d = 1'b0;
        illegal_d = illegal_q;
        wen_s     = 1'b0;
        if (prog_we || illegal_q) begin
            pc_d = pc_q;
        end else if (legal_s) begin
            pc_d      = pc_q + 32'd4;
            retired_d = 1'b1;
            wen_s     = (rd_s != 5'd0);
        end else begin
            illegal_d = 1'b1;
        end
    end

    // Program memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_wdata;
        end
    end

    // Register file: cleared by reset, x0 never written
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wen_s) begin
            regs_q[rd_s] <= result_s;
        end
    end

    // Core state registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_q      <= RESET_PC;
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign pc      = pc_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_tb_core_mem.sv
// Scoreboard bench for tb_core_mem: directed programs push expected retirements,
// a negedge monitor pops and checks pc and the destination register on every retire.
module tb_tb_core_mem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_wdata;
    logic [4:0]  dbg_raddr, stim_raddr, mon_raddr;
    logic        mon_sel;
    logic [31:0] dbg_rdata, pc;
    logic        retired, illegal;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          retire_cnt = 0;
    int          base_cnt;
    logic [31:0] prog_buf [16];

    always #5 clk = ~clk;
    assign dbg_raddr = mon_sel ? mon_raddr : stim_raddr;

    tb_core_mem dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .pc         (pc),
        .retired    (retired),
        .illegal    (illegal)
    );

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [4:0] rd);
        return {7'b0000000, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_ret(input logic [31:0] p, input logic [4:0] rd, input logic [31:0] v);
        exp_t e;
        e.pc  = p;
        e.rd  = rd;
        e.val = v;
        sb_q.push_back(e);
    endtask

    // Loads prog_buf[0..n-1] while reset is held
    task automatic load_prog(input int n);
        rst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            prog_we    = 1'b1;
            prog_addr  = i[7:0];
            prog_wdata = prog_buf[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        #2;
        check({name, "_drain"}, sb_q.size(), 32'd0);
    endtask

    // Releases reset, lets the program run to its halt, then checks final state
    task automatic run_prog(input string name, input logic [31:0] exp_pc, input int exp_ret);
        base_cnt = retire_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        drain(name);
        repeat (3) @(negedge clk);
        #2;
        check({name, "_pc"}, pc, exp_pc);
        check({name, "_illegal"}, {31'd0, illegal}, 32'd1);
        check({name, "_retired_idle"}, {31'd0, retired}, 32'd0);
        check({name, "_retire_count"}, retire_cnt - base_cnt, exp_ret);
    endtask

    // Monitor: every retire must match the oldest scoreboard entry
    initial begin
        exp_t e;
        mon_sel   = 1'b0;
        mon_raddr = 5'd0;
        forever begin
            @(negedge clk);
            if (retired === 1'b1) begin
                retire_cnt++;
                check("sb_nonempty_on_retire", {31'd0, (sb_q.size() != 0)}, 32'd1);
                if (sb_q.size() != 0) begin
                    e         = sb_q.pop_front();
                    mon_raddr = e.rd;
                    mon_sel   = 1'b1;
                    #1;
                    check("retire_pc", pc, e.pc);
                    check($sformatf("retire_x%0d", e.rd), dbg_rdata, e.val);
                    mon_sel = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = 8'd0;
        prog_wdata = 32'd0;
        stim_raddr = 5'd0;

        // ADD with a negative immediate
        prog_buf[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1);
        prog_buf[1] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2);
        prog_buf[2] = enc_r(3'b000, 5'd1, 5'd2, 5'd3);
        prog_buf[3] = 32'h0000_0000;
        load_prog(4);
        #2;
        check("reset_pc", pc, 32'd0);
        check("reset_retired", {31'd0, retired}, 32'd0);
        check("reset_illegal", {31'd0, illegal}, 32'd0);
        expect_ret(32'd4, 5'd1, 32'd5);
        expect_ret(32'd8, 5'd2, 32'hFFFF_FFFD);
        expect_ret(32'd12, 5'd3, 32'd2);
        run_prog("add", 32'd12, 3);

        // AND / ANDI
        prog_buf[0] = enc_i(12'h0F0, 5'd0, 3'b000, 5'd1);
        prog_buf[1] = enc_i(12'h03C, 5'd1, 3'b111, 5'd2);
        prog_buf[2] = enc_r(3'b111, 5'd1, 5'd2, 5'd3);
        prog_buf[3] = 32'h0000_0000;
        load_prog(4);
        expect_ret(32'd4, 5'd1, 32'h0000_00F0);
        expect_ret(32'd8, 5'd2, 32'h0000_0030);
        expect_ret(32'd12, 5'd3, 32'h0000_0030);
        run_prog("and", 32'd12, 3);

        // SLLI edge shifts, then SLLI with nonzero upper bits is illegal
        prog_buf[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1);
        prog_buf[1] = enc_i(12'h01F, 5'd1, 3'b001, 5'd2);
        prog_buf[2] = enc_i(12'h000, 5'd1, 3'b001, 5'd3);
        prog_buf[3] = enc_i(12'h401, 5'd1, 3'b001, 5'd4);
        load_prog(4);
        expect_ret(32'd4, 5'd1, 32'd1);
        expect_ret(32'd8, 5'd2, 32'h8000_0000);
        expect_ret(32'd12, 5'd3, 32'd1);
        run_prog("slli", 32'd12, 3);
        stim_raddr = 5'd4;
        #1;
        check("slli_bad_no_write_x4", dbg_rdata, 32'd0);

        // SLTI / SLTIU signed vs unsigned, ADD wrap, XORI is unsupported
        prog_buf[0] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1);
        prog_buf[1] = enc_i(12'h000, 5'd1, 3'b010, 5'd2);
        prog_buf[2] = enc_i(12'h000, 5'd1, 3'b011, 5'd3);
        prog_buf[3] = enc_i(12'hFFF, 5'd0, 3'b011, 5'd4);
        prog_buf[4] = enc_i(12'hFFF, 5'd0, 3'b010, 5'd5);
        prog_buf[5] = enc_r(3'b000, 5'd1, 5'd1, 5'd6);
        prog_buf[6] = enc_i(12'h001, 5'd1, 3'b100, 5'd7);
        load_prog(7);
        expect_ret(32'd4, 5'd1, 32'hFFFF_FFFF);
        expect_ret(32'd8, 5'd2, 32'd1);
        expect_ret(32'd12, 5'd3, 32'd0);
        expect_ret(32'd16, 5'd4, 32'd1);
        expect_ret(32'd20, 5'd5, 32'd0);
        expect_ret(32'd24, 5'd6, 32'hFFFF_FFFE);
        run_prog("slt", 32'd24, 6);
        stim_raddr = 5'd7;
        #1;
        check("xori_no_write_x7", dbg_rdata, 32'd0);

        // Writes to x0 are discarded; async reset clears the halt
        prog_buf[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd0);
        prog_buf[1] = 32'h0000_0000;
        load_prog(2);
        expect_ret(32'd4, 5'd0, 32'd0);
        run_prog("x0", 32'd4, 1);
        stim_raddr = 5'd0;
        #1;
        check("x0_reads_zero", dbg_rdata, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("async_rst_illegal", {31'd0, illegal}, 32'd0);
        check("async_rst_pc", pc, 32'd0);

        // Reset after two instructions, then identical re-run with a stall
        prog_buf[0] = enc_i(12'd11, 5'd0, 3'b000, 5'd1);
        prog_buf[1] = enc_i(12'd22, 5'd0, 3'b000, 5'd2);
        prog_buf[2] = enc_i(12'd33, 5'd0, 3'b000, 5'd3);
        prog_buf[3] = 32'h0000_0000;
        load_prog(4);
        expect_ret(32'd4, 5'd1, 32'd11);
        expect_ret(32'd8, 5'd2, 32'd22);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("midrst_pc", pc, 32'd0);
        check("midrst_retired", {31'd0, retired}, 32'd0);
        check("midrst_sb_empty", sb_q.size(), 32'd0);
        stim_raddr = 5'd1;
        #1;
        check("midrst_x1", dbg_rdata, 32'd0);
        stim_raddr = 5'd2;
        #1;
        check("midrst_x2", dbg_rdata, 32'd0);

        expect_ret(32'd4, 5'd1, 32'd11);
        expect_ret(32'd8, 5'd2, 32'd22);
        expect_ret(32'd12, 5'd3, 32'd33);
        base_cnt = retire_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        prog_we    = 1'b1;
        prog_addr  = 8'd10;
        prog_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        prog_we = 1'b0;
        check("stall_retired", {31'd0, retired}, 32'd0);
        check("stall_pc", pc, 32'd4);
        drain("rerun");
        repeat (3) @(negedge clk);
        #2;
        check("rerun_pc", pc, 32'd12);
        check("rerun_illegal", {31'd0, illegal}, 32'd1);
        check("rerun_retire_count", retire_cnt - base_cnt, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_core_mem.md
TB_CORE_MEM -- requirements
Module: tb_core_mem

Interface
REQ-001 Parameter PROG_WORDS, default 256, instruction memory depth in 32-bit words (power of two).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high (asserted = 1), despite the name.
REQ-005 prog_we  input  1  program-memory write enable.
REQ-006 prog_addr  input  log2(PROG_WORDS)  program-memory word address.
REQ-007 prog_wdata  input  32  instruction word to write.
REQ-008 dbg_raddr  input  5  register-file debug read address.
REQ-009 dbg_rdata  output  32  combinational value of register dbg_raddr (x0 reads 0).
REQ-010 pc  output  32  current program counter.
REQ-011 retired  output  1  registered pulse: an instruction completed in the previous cycle.
REQ-012 illegal  output  1  sticky flag: an unsupported encoding was fetched; core halted.

Function
REQ-013 Single-cycle RV32I subset core: fetch mem[pc[log2(PROG_WORDS)+1:2]], decode, execute and write back in one clock, then pc <= pc+4.
REQ-014 Supported R-type (opcode 0110011, funct7 0000000): ADD funct3 000 (rd=rs1+rs2, mod 2^32); AND funct3 111.
REQ-015 Supported I-type (opcode 0010011), imm = sign-extended inst[31:20]: ADDI 000; ANDI 111; SLTI 010 (signed rs1<imm ? 1:0); SLTIU 011 (unsigned rs1 < sign-extended imm ? 1:0).
REQ-016 SLLI: opcode 0010011, funct3 001, inst[31:25]=0000000; rd = rs1 << inst[24:20].
REQ-017 Register file 32x32; x0 reads 0 and writes to x0 are discarded; two combinational reads (rs1, rs2) plus the debug read.
REQ-018 Any other encoding (including SLLI with nonzero inst[31:25]): no register write, pc holds, illegal <= 1, retired <= 0; core stays halted until reset.
REQ-019 Program memory has one write port; prog_we=1 writes prog_wdata at prog_addr on the rising edge and stalls the core that cycle (no fetch/execute, pc holds, retired=0).
REQ-020 Program memory contents are not affected by reset; loading is allowed during or after reset.
REQ-021 Fetch index wraps modulo PROG_WORDS; pc itself increments over the full 32 bits (2^32 wrap to 0).
REQ-022 retired=1 in the cycle after each successful execute; never asserted while in reset, stalled or halted.
REQ-023 Read-during-write to the same register in one cycle: the read returns the old value (write takes effect at the edge).
REQ-024 No data memory, branches, loads or stores in this block.

Reset
REQ-025 On rst_n=1 (asynchronous): pc=RESET_PC, all registers x1..x31 = 0, illegal=0, retired=0.
REQ-026 While rst_n=1, no instruction executes; the first fetch occurs on the first rising edge after deassertion.
REQ-027 Reset asserted mid-program aborts immediately; registers written by earlier instructions are cleared.

Verification
REQ-028 ADD: load ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; release reset, 3 cycles -> x3=2, pc=12, retired pulses 3 times.
REQ-029 AND/ANDI: x1=0x0F0 (ADDI), ANDI x2,x1,0x03C; AND x3,x1,x2 -> x2=0x030, x3=0x030.
REQ-030 SLLI: x1=1, SLLI x2,x1,31 -> x2=0x8000_0000; SLLI x3,x1,0 -> x3=1.
REQ-031 SLTI/SLTIU: x1=-1; SLTI x2,x1,0 -> 1; SLTIU x3,x1,0 -> 0; SLTIU x4,x0,-1 -> 1.
REQ-032 Illegal/x0: ADDI x0,x0,7 then word 0x0000_0000 -> x0 reads 0, illegal=1, pc stays 4; asserting rst_n clears illegal and pc=0.
REQ-033 Reset mid-run: assert rst_n after two instructions -> all registers 0, pc=0; program memory unchanged, and the program re-executes identically after release.
